// File: rtl/mem_sig_pkg.sv
// Shared types and default address map for the data-memory signature monitor.
// Holds monitor states, stop reasons and a default-width dump record builder.
package mem_sig_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        REASON_NONE   = 2'd0,
        REASON_STOP   = 2'd1,
        REASON_SIMLEN = 2'd2,
        REASON_TRAP   = 2'd3
    } stop_reason_e;

    localparam logic [63:0] DEF_STOP_ADDR = 64'h0;
    localparam logic [63:0] DEF_TRAP_ADDR = 64'h8;
    localparam logic [63:0] DEF_CH_BASE   = 64'h10;
    localparam int          CH_STRIDE     = 8;

    localparam int DEF_CH_W   = 1;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_DATA_W = 64;

    // Record layout for the default configuration (2 channels, 32-bit index, 64-bit data).
    typedef struct packed {
        logic [DEF_CH_W-1:0]   ch;
        logic [DEF_CNT_W-1:0]  idx;
        logic [DEF_DATA_W-1:0] data;
    } dump_rec_t;

    function automatic dump_rec_t make_dump_rec(input logic [DEF_CH_W-1:0]   ch,
                                                input logic [DEF_CNT_W-1:0]  idx,
                                                input logic [DEF_DATA_W-1:0] data);
        dump_rec_t r;
        r.ch   = ch;
        r.idx  = idx;
        r.data = data;
        return r;
    endfunction

    function automatic logic [63:0] chan_addr(input logic [63:0] base, input int c);
        return base + 64'(CH_STRIDE * c);
    endfunction

endpackage

// File: rtl/mem_sig_monitor_if.sv
// Bundle of the snooped memory write port, run-length control and dump-record stream.
// master drives the memory port and consumer ready; slave is the monitor.
interface mem_sig_monitor_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [CNT_W-1:0]  simlen_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [CH_W-1:0]   dump_ch_o;
    logic [CNT_W-1:0]  dump_idx_o;
    logic [DATA_W-1:0] dump_data_o;
    logic              done_o;
    logic [1:0]        stop_reason_o;
    logic [CNT_W-1:0]  cycle_cnt_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    modport master (
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, simlen_i, dump_ready_i,
        input  dump_valid_o, dump_ch_o, dump_idx_o, dump_data_o,
               done_o, stop_reason_o, cycle_cnt_o, drop_cnt_o
    );

    modport slave (
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, simlen_i, dump_ready_i,
        output dump_valid_o, dump_ch_o, dump_idx_o, dump_data_o,
               done_o, stop_reason_o, cycle_cnt_o, drop_cnt_o
    );

endinterface

// File: rtl/mem_sig_fifo.sv
// Synchronous FIFO; head visible the cycle after push, pop_dat reads 0 when empty.
// A push while full is accepted only with a concurrent pop, otherwise ignored (caller counts it).
module mem_sig_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/mem_sig_monitor.sv
// Snoops data-memory writes for stop/trap/dump signatures; dumps leave one cycle after the write via a ready/valid FIFO.
// Full FIFO drops new records (counted); MEM_SIG_TRAP_STOP_EN makes a trap write start the drain like a stop.
module mem_sig_monitor
    import mem_sig_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                DATA_W     = 64,
    parameter int                NUM_CH     = 2,
    parameter logic [ADDR_W-1:0] CH_BASE    = ADDR_W'(DEF_CH_BASE),
    parameter logic [ADDR_W-1:0] STOP_ADDR  = ADDR_W'(DEF_STOP_ADDR),
    parameter logic [ADDR_W-1:0] TRAP_ADDR  = ADDR_W'(DEF_TRAP_ADDR),
    parameter int                STOP_DRAIN = 50,
    parameter int                FIFO_DEPTH = 8,
    parameter int                CNT_W      = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_sig_monitor_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef MEM_SIG_TRAP_STOP_EN
    localparam bit TRAP_STOP_EN = 1'b1;
`else
    localparam bit TRAP_STOP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [CNT_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } rec_t;

    mon_state_e   state, state_nxt;
    stop_reason_e reason, reason_nxt;
    logic [CNT_W-1:0] drain_cnt, drain_nxt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] idx_q [NUM_CH];

    logic            wr;
    logic            stop_hit;
    logic            trap_hit;
    logic            simlen_hit;
    logic            ch_hit;
    logic [CH_W-1:0] ch_sel;
    logic            push_req;
    logic            pop;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    rec_t            push_rec;
    rec_t            head_rec;

    assign wr         = bus.mem_req_i && bus.mem_we_i;
    assign stop_hit   = wr && (bus.mem_addr_i == STOP_ADDR);
    assign trap_hit   = TRAP_STOP_EN && wr && (bus.mem_addr_i == TRAP_ADDR);
    assign simlen_hit = (state != DONE) && (bus.simlen_i != '0) &&
                        (cycle_cnt == bus.simlen_i - CNT_W'(1));

    // The drain is counted so that DONE is entered STOP_DRAIN+1 cycles after the stop write.
    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        reason_nxt = reason;
        case (state)
            RUN: begin
                if (simlen_hit) begin
                    state_nxt  = DONE;
                    reason_nxt = REASON_SIMLEN;
                end else if (stop_hit || trap_hit) begin
                    reason_nxt = stop_hit ? REASON_STOP : REASON_TRAP;
                    drain_nxt  = CNT_W'(STOP_DRAIN);
                    state_nxt  = (STOP_DRAIN == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (simlen_hit) begin
                    state_nxt  = DONE;
                    reason_nxt = REASON_SIMLEN;
                end else if (drain_cnt <= CNT_W'(1)) begin
                    state_nxt = DONE;
                    drain_nxt = '0;
                end else begin
                    drain_nxt = drain_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = DONE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            reason    <= REASON_NONE;
            drain_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            reason    <= reason_nxt;
            drain_cnt <= drain_nxt;
            if (state != DONE) cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        ch_hit = 1'b0;
        ch_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.mem_addr_i == CH_BASE + ADDR_W'(CH_STRIDE * c)) begin
                ch_hit = 1'b1;
                ch_sel = CH_W'(c);
            end
        end
    end

    assign push_req      = wr && ch_hit && (state == RUN);
    assign push_rec.ch   = ch_sel;
    assign push_rec.idx  = idx_q[ch_sel];
    assign push_rec.data = bus.mem_wdata_i;

    // The index advances on every captured dump, whether or not the FIFO had room.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) idx_q[c] <= '0;
        end else if (push_req) begin
            idx_q[ch_sel] <= idx_q[ch_sel] + CNT_W'(1);
        end
    end

    assign pop  = bus.dump_ready_i && !fifo_empty;
    assign drop = push_req && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    mem_sig_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push_req),
        .push_dat (push_rec),
        .pop      (pop),
        .pop_dat  (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.dump_valid_o  = !fifo_empty;
    assign bus.dump_ch_o     = head_rec.ch;
    assign bus.dump_idx_o    = head_rec.idx;
    assign bus.dump_data_o   = head_rec.data;
    assign bus.done_o        = (state == DONE);
    assign bus.stop_reason_o = reason;
    assign bus.cycle_cnt_o   = cycle_cnt;
    assign bus.drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_mem_sig_monitor.sv
// Self-checking bench for mem_sig_monitor: timed scenarios plus a dump-record scoreboard.
// Build with +define+MEM_SIG_TRAP_STOP_EN to exercise the trap-as-stop option.
module tb_mem_sig_monitor;
    import mem_sig_pkg::*;

    localparam int STOP_DRAIN = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sig_monitor_if #(.ADDR_W(64), .DATA_W(64), .NUM_CH(2), .CNT_W(32)) bus ();

    mem_sig_monitor #(
        .ADDR_W(64), .DATA_W(64), .NUM_CH(2),
        .CH_BASE(64'h10), .STOP_ADDR(64'h0), .TRAP_ADDR(64'h8),
        .STOP_DRAIN(STOP_DRAIN), .FIFO_DEPTH(8), .CNT_W(32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int        checks   = 0;
    int        failures = 0;
    dump_rec_t sb [$];

    // Scoreboard: a handshake is decided by values stable from this negedge to the next posedge.
    always @(negedge clk) begin : monitor
        dump_rec_t e;
        dump_rec_t o;
        if (!rst && bus.dump_valid_o && bus.dump_ready_i) begin
            o = make_dump_rec(bus.dump_ch_o, bus.dump_idx_o, bus.dump_data_o);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL record_unexpected got ch=%0d idx=%0d data=%h, none expected", o.ch, o.idx, o.data);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL record got ch=%0d idx=%0d data=%h, expected ch=%0d idx=%0d data=%h",
                             o.ch, o.idx, o.data, e.ch, e.idx, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete, expected completion before 400us");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_wdata_i = '0;
    endtask

    task automatic write(input logic [63:0] addr, input logic [63:0] data);
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = data;
    endtask

    // Leaves the bench at the start of cycle 0: the first cycle with reset low.
    task automatic do_reset();
        rst = 1'b1;
        idle();
        bus.dump_ready_i = 1'b0;
        bus.simlen_i     = '0;
        sb.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        ok = (sb.size() == 0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.done_o, bus.dump_valid_o, bus.stop_reason_o} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got done=%b valid=%b reason=%0d, expected 0 0 0",
                     bus.done_o, bus.dump_valid_o, bus.stop_reason_o);
        end
        checks++;
        if ({bus.cycle_cnt_o, bus.drop_cnt_o, bus.dump_idx_o, bus.dump_data_o, bus.dump_ch_o} !== '0) begin
            failures++;
            $display("FAIL reset_values got cycle=%0d drop=%0d idx=%0d data=%h ch=%0d, expected all 0",
                     bus.cycle_cnt_o, bus.drop_cnt_o, bus.dump_idx_o, bus.dump_data_o, bus.dump_ch_o);
        end
        repeat (3) step();
        checks++;
        if (bus.cycle_cnt_o !== 32'd3) begin
            failures++;
            $display("FAIL cycle_count_start got %0d, expected 3", bus.cycle_cnt_o);
        end
    endtask

    task automatic test_stop();
        do_reset();
        bus.dump_ready_i = 1'b1;
        repeat (5) step();
        checks++;
        if (bus.stop_reason_o !== 2'd0) begin
            failures++;
            $display("FAIL reason_in_run got %0d, expected 0", bus.stop_reason_o);
        end
        write(64'h0, 64'h1);           // stop write in cycle 5
        step();
        idle();
        checks++;
        if (bus.stop_reason_o !== 2'd1 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_enter_drain got reason=%0d done=%b, expected 1 0", bus.stop_reason_o, bus.done_o);
        end
        write(64'h10, rnd64());        // dump while draining must be ignored
        step();
        idle();
        checks++;
        if (bus.dump_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL dump_in_drain got valid=%b, expected 0", bus.dump_valid_o);
        end
        repeat (48) step();            // cycle 55
        checks++;
        if (bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL done_early got done=%b at cycle 55, expected 0", bus.done_o);
        end
        step();                        // cycle 56
        checks++;
        if (bus.done_o !== 1'b1 || bus.stop_reason_o !== 2'd1 || bus.cycle_cnt_o !== 32'd56) begin
            failures++;
            $display("FAIL stop_done got done=%b reason=%0d cycle=%0d, expected 1 1 56",
                     bus.done_o, bus.stop_reason_o, bus.cycle_cnt_o);
        end
        repeat (5) step();
        checks++;
        if (bus.done_o !== 1'b1 || bus.cycle_cnt_o !== 32'd56) begin
            failures++;
            $display("FAIL done_frozen got done=%b cycle=%0d, expected 1 56", bus.done_o, bus.cycle_cnt_o);
        end
    endtask

    task automatic test_dump_order();
        logic [63:0] a, b, c;
        bit ok;
        do_reset();
        bus.dump_ready_i = 1'b1;
        a = rnd64(); b = rnd64(); c = rnd64();
        write(64'h10, a); sb.push_back(make_dump_rec(1'b0, 32'd0, a)); step();
        checks++;
        if (bus.dump_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL dump_latency got valid=%b one cycle after push, expected 1", bus.dump_valid_o);
        end
        write(64'h18, b); sb.push_back(make_dump_rec(1'b1, 32'd0, b)); step();
        write(64'h10, c); sb.push_back(make_dump_rec(1'b0, 32'd1, c)); step();
        bus.mem_we_i = 1'b0;           // read request to a channel address is not a dump
        step();
        idle();
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dump_order_timeout got %0d records pending, expected 0", sb.size());
        end
        step();
        checks++;
        if (bus.dump_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL dump_extra got valid=%b, expected 0", bus.dump_valid_o);
        end
    endtask

    task automatic test_simlen();
        do_reset();
        bus.simlen_i = 32'd100;
        repeat (99) step();
        checks++;
        if (bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL simlen_early got done=%b at cycle 99, expected 0", bus.done_o);
        end
        step();
        checks++;
        if (bus.done_o !== 1'b1 || bus.stop_reason_o !== 2'd2 || bus.cycle_cnt_o !== 32'd100) begin
            failures++;
            $display("FAIL simlen_done got done=%b reason=%0d cycle=%0d, expected 1 2 100",
                     bus.done_o, bus.stop_reason_o, bus.cycle_cnt_o);
        end
    endtask

    task automatic test_simlen_vs_stop();
        do_reset();
        bus.simlen_i = 32'd100;
        repeat (99) step();
        write(64'h0, 64'h1);
        step();
        idle();
        checks++;
        if (bus.done_o !== 1'b1 || bus.stop_reason_o !== 2'd2) begin
            failures++;
            $display("FAIL simlen_priority got done=%b reason=%0d, expected 1 2", bus.done_o, bus.stop_reason_o);
        end
        do_reset();
        bus.simlen_i = 32'd30;
        repeat (5) step();
        write(64'h0, 64'h1);
        step();
        idle();
        repeat (24) step();            // cycle 30
        checks++;
        if (bus.done_o !== 1'b1 || bus.stop_reason_o !== 2'd2 || bus.cycle_cnt_o !== 32'd30) begin
            failures++;
            $display("FAIL simlen_in_drain got done=%b reason=%0d cycle=%0d, expected 1 2 30",
                     bus.done_o, bus.stop_reason_o, bus.cycle_cnt_o);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [63:0] d [10];
        logic [63:0] x;
        bit ok;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            d[i] = rnd64();
            write(64'h10, d[i]);
            if (i < 8) sb.push_back(make_dump_rec(1'b0, 32'(i), d[i]));
            step();
        end
        idle();
        checks++;
        if (bus.drop_cnt_o !== 32'd2) begin
            failures++;
            $display("FAIL drop_count got %0d, expected 2", bus.drop_cnt_o);
        end
        checks++;
        if (bus.dump_valid_o !== 1'b1 || bus.dump_idx_o !== 32'd0 || bus.dump_data_o !== d[0]) begin
            failures++;
            $display("FAIL stall_hold got valid=%b idx=%0d data=%h, expected 1 0 %h",
                     bus.dump_valid_o, bus.dump_idx_o, bus.dump_data_o, d[0]);
        end
        bus.dump_ready_i = 1'b1;
        wait_drain(30, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL overflow_drain_timeout got %0d records pending, expected 0", sb.size());
        end
        x = rnd64();
        write(64'h10, x);
        sb.push_back(make_dump_rec(1'b0, 32'd10, x));
        step();
        idle();
        wait_drain(10, ok);
        checks++;
        if (!ok || bus.drop_cnt_o !== 32'd2) begin
            failures++;
            $display("FAIL post_drop_index got pending=%0d drop=%0d, expected 0 2", sb.size(), bus.drop_cnt_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] v;
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = rnd64();
            write(64'h18, v);
            sb.push_back(make_dump_rec(1'b1, 32'(i), v));
            step();
        end
        v = rnd64();
        write(64'h18, v);              // FIFO full: accepted only because a pop happens too
        sb.push_back(make_dump_rec(1'b1, 32'd8, v));
        bus.dump_ready_i = 1'b1;
        step();
        idle();
        wait_drain(20, ok);
        checks++;
        if (!ok || bus.drop_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL full_push_pop got pending=%0d drop=%0d, expected 0 0", sb.size(), bus.drop_cnt_o);
        end
    endtask

    task automatic test_trap();
        bit ok;
        logic [63:0] v;
        do_reset();
        bus.dump_ready_i = 1'b1;
        repeat (2) step();
        write(64'h8, 64'hdead);        // trap write in cycle 2
        step();
        idle();
`ifdef MEM_SIG_TRAP_STOP_EN
        checks++;
        if (bus.stop_reason_o !== 2'd3) begin
            failures++;
            $display("FAIL trap_reason got %0d, expected 3", bus.stop_reason_o);
        end
        repeat (49) step();            // cycle 52
        checks++;
        if (bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL trap_done_early got done=%b, expected 0", bus.done_o);
        end
        step();                        // cycle 53
        checks++;
        if (bus.done_o !== 1'b1 || bus.stop_reason_o !== 2'd3) begin
            failures++;
            $display("FAIL trap_done got done=%b reason=%0d, expected 1 3", bus.done_o, bus.stop_reason_o);
        end
`else
        checks++;
        if (bus.stop_reason_o !== 2'd0) begin
            failures++;
            $display("FAIL trap_ignored_reason got %0d, expected 0", bus.stop_reason_o);
        end
        repeat (50) step();            // cycle 53
        checks++;
        if (bus.done_o !== 1'b0 || bus.stop_reason_o !== 2'd0) begin
            failures++;
            $display("FAIL trap_ignored_done got done=%b reason=%0d, expected 0 0", bus.done_o, bus.stop_reason_o);
        end
        v = rnd64();
        write(64'h10, v);
        sb.push_back(make_dump_rec(1'b0, 32'd0, v));
        step();
        idle();
        wait_drain(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL trap_ignored_capture got %0d records pending, expected 0", sb.size());
        end
`endif
    endtask

    task automatic test_reset_mid_drain();
        logic [63:0] v;
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            write(64'h18, rnd64());
            step();
        end
        write(64'h0, 64'h1);
        step();
        idle();
        repeat (3) step();
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        checks++;
        if (bus.dump_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.stop_reason_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_drain_flags got valid=%b done=%b reason=%0d, expected 0 0 0",
                     bus.dump_valid_o, bus.done_o, bus.stop_reason_o);
        end
        checks++;
        if ({bus.cycle_cnt_o, bus.drop_cnt_o, bus.dump_data_o, bus.dump_idx_o} !== '0) begin
            failures++;
            $display("FAIL reset_drain_values got cycle=%0d drop=%0d data=%h idx=%0d, expected all 0",
                     bus.cycle_cnt_o, bus.drop_cnt_o, bus.dump_data_o, bus.dump_idx_o);
        end
        bus.dump_ready_i = 1'b1;
        v = rnd64();
        write(64'h18, v);
        sb.push_back(make_dump_rec(1'b1, 32'd0, v));
        step();
        idle();
        wait_drain(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_drain_run got %0d records pending, expected 0", sb.size());
        end
    endtask

    initial begin
        idle();
        bus.dump_ready_i = 1'b0;
        bus.simlen_i     = '0;
        test_reset();
        test_stop();
        test_dump_order();
        test_simlen();
        test_simlen_vs_stop();
        test_fifo_overflow();
        test_full_push_pop();
        test_trap();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
